// File: rtl/cmp_window_stats.sv
// Windowed statistics on comparator samples; the report registers on the edge accepting the WINDOW-th sample.
// in_ready is low while a report is held; the report holds until out_ready, and the upstream must hold its sample.
module cmp_window_stats #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             greater,
  input  logic             lesser,
  input  logic             equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] eq_run_max,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] min_b
);

  typedef enum logic {ACCUM, REPORT} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] gt;
    logic [CNT_W-1:0] lt;
    logic [CNT_W-1:0] eq;
    logic [CNT_W-1:0] err;
    logic [CNT_W-1:0] run_max;
    logic [WIDTH-1:0] max_a;
    logic [WIDTH-1:0] min_b;
  } stats_t;

  // Window-start values: all counts and max_a zero, min_b saturated high.
  localparam stats_t STATS_INIT = stats_t'({{(5*CNT_W+WIDTH){1'b0}}, {WIDTH{1'b1}}});
  localparam int SCW = 8;

  state_t           state_q, state_d;
  logic [SCW-1:0]   sample_cnt;
  logic [CNT_W-1:0] run_q, run_d;
  stats_t           acc_q, acc_d, rpt_q;
  logic             accept, last_sample;
  logic             a_gt, a_lt, a_eq, flag_err;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_sample) state_d = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign last_sample = (sample_cnt == SCW'(WINDOW - 1));

  // Classification always follows the internal compare; the flags only feed the error count.
  always_comb begin
    a_gt     = (a > b);
    a_lt     = (a < b);
    a_eq     = (a == b);
    flag_err = ({greater, lesser, equal} != {a_gt, a_lt, a_eq});
    run_d    = a_eq ? run_q + CNT_W'(1) : '0;
    acc_d         = acc_q;
    acc_d.gt      = acc_q.gt  + CNT_W'(a_gt);
    acc_d.lt      = acc_q.lt  + CNT_W'(a_lt);
    acc_d.eq      = acc_q.eq  + CNT_W'(a_eq);
    acc_d.err     = acc_q.err + CNT_W'(flag_err);
    acc_d.run_max = (run_d > acc_q.run_max) ? run_d : acc_q.run_max;
    acc_d.max_a   = (a > acc_q.max_a) ? a : acc_q.max_a;
    acc_d.min_b   = (b < acc_q.min_b) ? b : acc_q.min_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      sample_cnt <= '0;
      run_q      <= '0;
      acc_q      <= STATS_INIT;
      rpt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (last_sample) begin
          rpt_q      <= acc_d;
          acc_q      <= STATS_INIT;
          run_q      <= '0;
          sample_cnt <= '0;
        end else begin
          acc_q      <= acc_d;
          run_q      <= run_d;
          sample_cnt <= sample_cnt + SCW'(1);
        end
      end
    end
  end

  assign gt_count   = rpt_q.gt;
  assign lt_count   = rpt_q.lt;
  assign eq_count   = rpt_q.eq;
  assign err_count  = rpt_q.err;
  assign eq_run_max = rpt_q.run_max;
  assign max_a      = rpt_q.max_a;
  assign min_b      = rpt_q.min_b;

endmodule
